// File: rtl/ramp_pattern_gen.sv
// Programmable ramp generator: sawtooth up/down and triangle shapes
// between lo and hi, with wrap or saturate at the end of range.
module ramp_pattern_gen #(
   parameter int WIDTH  = 12,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ramp_enb,
   input  logic              delta,
   input  logic              restart,
   input  logic [1:0]        mode,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  lo,
   input  logic [WIDTH-1:0]  hi,
   input  logic              sat_en,
   output logic [WIDTH-1:0]  out,
   output logic              dir,
   output logic              wrap_pulse
);

   localparam logic [1:0] M_HOLD = 2'b00;
   localparam logic [1:0] M_UP   = 2'b01;
   localparam logic [1:0] M_DN   = 2'b10;
   localparam logic [1:0] M_TRI  = 2'b11;

   logic [WIDTH-1:0] out_q, out_d;
   logic             dir_q, dir_d;
   logic             pulse_q, pulse_d;

   // One extra bit keeps the carry/borrow so compares never alias.
   logic [WIDTH:0] out_x, lo_x, hi_x, step_x;
   logic [WIDTH:0] up_n, dn_n;
   logic           up_le_hi, up_ge_hi;
   logic           dn_ge_lo, dn_le_lo;
   logic           adv, cfg_err, out_rng;
   logic [WIDTH-1:0] start_v;

   assign out_x  = {1'b0, out_q};
   assign lo_x   = {1'b0, lo};
   assign hi_x   = {1'b0, hi};
   assign step_x = (WIDTH+1)'(step);

   assign up_n = out_x + step_x;
   assign dn_n = out_x - step_x;

   assign up_le_hi = up_n <= hi_x;
   assign up_ge_hi = up_n >= hi_x;
   assign dn_ge_lo = $signed(dn_n) >= $signed(lo_x);
   assign dn_le_lo = $signed(dn_n) <= $signed(lo_x);

   assign adv     = ramp_enb & delta & (mode != M_HOLD);
   assign cfg_err = lo > hi;
   assign out_rng = (out_q < lo) | (out_q > hi);
   assign start_v = (mode == M_DN) ? hi : lo;

   always_comb begin
      out_d   = out_q;
      dir_d   = dir_q;
      pulse_d = 1'b0;
      if (restart) begin
         out_d = start_v;
         dir_d = 1'b0;
      end else if (adv) begin
         if (cfg_err) begin
            out_d = lo;
            dir_d = 1'b0;
         end else if (out_rng) begin
            out_d = start_v;
            dir_d = 1'b0;
         end else if (step_x != '0) begin
            case (mode)
               M_UP: begin
                  if (up_le_hi) begin
                     out_d = up_n[WIDTH-1:0];
                  end else if (sat_en) begin
                     out_d = hi;
                  end else begin
                     out_d   = lo;
                     pulse_d = 1'b1;
                  end
               end
               M_DN: begin
                  if (dn_ge_lo) begin
                     out_d = dn_n[WIDTH-1:0];
                  end else if (sat_en) begin
                     out_d = lo;
                  end else begin
                     out_d   = hi;
                     pulse_d = 1'b1;
                  end
               end
               M_TRI: begin
                  if (!dir_q) begin
                     if (up_ge_hi) begin
                        out_d   = hi;
                        dir_d   = 1'b1;
                        pulse_d = 1'b1;
                     end else begin
                        out_d = up_n[WIDTH-1:0];
                     end
                  end else begin
                     if (dn_le_lo) begin
                        out_d   = lo;
                        dir_d   = 1'b0;
                        pulse_d = 1'b1;
                     end else begin
                        out_d = dn_n[WIDTH-1:0];
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         dir_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         dir_q   <= dir_d;
         pulse_q <= pulse_d;
      end
   end

   assign out        = out_q;
   assign dir        = dir_q;
   assign wrap_pulse = pulse_q;

endmodule

// File: tb/tb_ramp_pattern_gen.sv
// Directed bench for ramp_pattern_gen: integer reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_ramp_pattern_gen;

   localparam int WIDTH  = 12;
   localparam int STEP_W = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              ramp_enb = 1'b0;
   logic              delta = 1'b0;
   logic              restart = 1'b0;
   logic [1:0]        mode = 2'b00;
   logic [STEP_W-1:0] step = '0;
   logic [WIDTH-1:0]  lo = '0;
   logic [WIDTH-1:0]  hi = '0;
   logic              sat_en = 1'b0;
   logic [WIDTH-1:0]  out;
   logic              dir;
   logic              wrap_pulse;

   int checks = 0;
   int failures = 0;
   bit started = 1'b0;

   int m_out = 0;
   int m_dir = 0;
   int m_pls = 0;

   ramp_pattern_gen #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk(clk), .rst_n(rst_n), .ramp_enb(ramp_enb), .delta(delta),
      .restart(restart), .mode(mode), .step(step), .lo(lo), .hi(hi),
      .sat_en(sat_en), .out(out), .dir(dir), .wrap_pulse(wrap_pulse)
   );

   always #5 clk = ~clk;

   // Reference model in plain integer arithmetic (no width limits).
   always @(posedge clk or negedge rst_n) begin
      int l, h, s, md;
      l = int'(lo); h = int'(hi); s = int'(step); md = int'(mode);
      if (!rst_n) begin
         m_out = 0; m_dir = 0; m_pls = 0;
      end else if (restart) begin
         m_out = (md == 2) ? h : l;
         m_dir = 0; m_pls = 0;
      end else if (ramp_enb && delta && md != 0) begin
         m_pls = 0;
         if (l > h) begin
            m_out = l; m_dir = 0;
         end else if (m_out < l || m_out > h) begin
            m_out = (md == 2) ? h : l;
            m_dir = 0;
         end else if (s != 0) begin
            if (md == 1) begin
               if (m_out + s <= h) m_out = m_out + s;
               else if (sat_en) m_out = h;
               else begin m_out = l; m_pls = 1; end
            end else if (md == 2) begin
               if (m_out - s >= l) m_out = m_out - s;
               else if (sat_en) m_out = l;
               else begin m_out = h; m_pls = 1; end
            end else if (m_dir == 0) begin
               if (m_out + s >= h) begin m_out = h; m_dir = 1; m_pls = 1; end
               else m_out = m_out + s;
            end else begin
               if (m_out - s <= l) begin m_out = l; m_dir = 0; m_pls = 1; end
               else m_out = m_out - s;
            end
         end
      end else begin
         m_pls = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (started) begin
         checks++;
         if (int'(out) != m_out || int'(dir) != m_dir ||
             int'(wrap_pulse) != m_pls) begin
            failures++;
            $display("FAIL model t=%0t out=%0d dir=%0d pls=%0d exp %0d/%0d/%0d",
                     $time, out, dir, wrap_pulse, m_out, m_dir, m_pls);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input int eo, input int ed,
                      input int ep);
      checks++;
      if (int'(out) != eo || int'(dir) != ed || int'(wrap_pulse) != ep) begin
         failures++;
         $display("FAIL %s out=%0d dir=%0d pls=%0d exp %0d/%0d/%0d",
                  nm, out, dir, wrap_pulse, eo, ed, ep);
      end
   endtask

   task automatic cfg(input int md, input int l, input int h, input int s,
                      input bit sat);
      mode = 2'(md); lo = WIDTH'(l); hi = WIDTH'(h);
      step = STEP_W'(s); sat_en = sat;
   endtask

   task automatic do_restart();
      restart = 1'b1; delta = 1'b0;
      tick();
      restart = 1'b0;
   endtask

   initial begin
      int exp_up[4]  = '{3, 6, 9, 0};
      int exp_sat[5] = '{3, 6, 9, 10, 10};
      int exp_dn[3]  = '{3, 1, 5};
      int exp_tri[5] = '{6, 8, 4, 2, 6};
      int tri_d[5]   = '{0, 1, 1, 0, 0};
      int tri_p[5]   = '{0, 1, 0, 1, 0};

      #1 rst_n = 1'b0;
      #1 chk("rst_async_start", 0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      started = 1'b1;
      tick();
      chk("reset_state", 0, 0, 0);

      ramp_enb = 1'b1;
      cfg(1, 0, 10, 3, 1'b0);
      do_restart();
      chk("up_restart", 0, 0, 0);
      delta = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("up_wrap%0d", i), exp_up[i], 0, (i == 3) ? 1 : 0);
      end

      sat_en = 1'b1;
      do_restart();
      delta = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("up_sat%0d", i), exp_sat[i], 0, 0);
      end

      // Async reset mid-ramp, between edges.
      sat_en = 1'b0;
      do_restart();
      delta = 1'b1;
      repeat (3) tick();
      chk("pre_reset_9", 9, 0, 0);
      delta = 1'b0;
      rst_n = 1'b0;
      #1 chk("rst_async_mid", 0, 0, 0);
      #1 rst_n = 1'b1;
      delta = 1'b1;
      tick();
      chk("post_reset_adv", 3, 0, 0);

      cfg(2, 0, 5, 2, 1'b0);
      do_restart();
      chk("dn_restart", 5, 0, 0);
      delta = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("dn_wrap%0d", i), exp_dn[i], 0, (i == 2) ? 1 : 0);
      end

      cfg(3, 2, 8, 4, 1'b0);
      do_restart();
      chk("tri_restart", 2, 0, 0);
      delta = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("tri%0d", i), exp_tri[i], tri_d[i], tri_p[i]);
      end

      ramp_enb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         delta = 1'b1; tick();
         delta = 1'b0; tick();
      end
      chk("enb_frozen", 6, 0, 0);
      do_restart();
      chk("restart_no_enb", 2, 0, 0);
      ramp_enb = 1'b1;
      mode = 2'b00;
      delta = 1'b1;
      tick(); tick();
      chk("mode_hold", 2, 0, 0);

      cfg(1, 0, 10, 3, 1'b0);
      do_restart();
      delta = 1'b1;
      repeat (3) tick();
      chk("edge_at9", 9, 0, 0);
      hi = 12'd6;
      tick();
      chk("range_fix", 0, 0, 0);
      lo = 12'd7; hi = 12'd3;
      tick();
      chk("cfg_err", 7, 0, 0);
      lo = 12'd0; hi = 12'd10; step = 8'd0;
      tick();
      chk("step_zero", 7, 0, 0);

      delta = 1'b0;
      cfg(1, 4000, 4095, 255, 1'b0);
      do_restart();
      chk("big_start", 4000, 0, 0);
      lo = 12'd0;
      delta = 1'b1;
      tick();
      chk("big_wrap", 0, 0, 1);
      delta = 1'b0;
      cfg(1, 4000, 4095, 255, 1'b1);
      do_restart();
      delta = 1'b1;
      tick();
      chk("big_sat", 4095, 0, 0);

      delta = 1'b0;
      cfg(3, 5, 5, 1, 1'b0);
      do_restart();
      delta = 1'b1;
      tick();
      chk("tri_eq0", 5, 1, 1);
      tick();
      chk("tri_eq1", 5, 0, 1);

      cfg(1, 5, 5, 2, 1'b0);
      tick();
      chk("saw_eq", 5, 0, 1);

      restart = 1'b1;
      cfg(2, 1, 9, 2, 1'b0);
      tick();
      chk("restart_wins", 9, 0, 0);
      restart = 1'b0;
      delta = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ramp_pattern_gen.md
# ramp_pattern_gen

Parametrised ramp pattern generator for the pattern datapath. It produces a WIDTH-bit ramp value that advances by a programmable step on each enabled `delta` strobe. Supported shapes are sawtooth-up, sawtooth-down and triangle. Bounds are programmable, and the end-of-range behaviour is selectable as wrap or saturate. It sits between the pattern-select control and the pixel/sample formatter, and supersedes the fixed 12-bit ramp.

## Interface
Parameters:
- `WIDTH`, 12, width of ramp value and bounds
- `STEP_W`, 8, width of step input

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ramp_enb`  in  1  enable; 0 freezes ramp state
- `delta`  in  1  advance strobe, sampled each clock
- `restart`  in  1  synchronous reload to start point
- `mode`  in  2  00 hold, 01 saw up, 10 saw down, 11 triangle
- `step`  in  STEP_W  increment magnitude (unsigned)
- `lo`  in  WIDTH  lower bound, inclusive
- `hi`  in  WIDTH  upper bound, inclusive
- `sat_en`  in  1  1 saturate at bound, 0 wrap (saw modes only)
- `out`  out  WIDTH  ramp value, registered
- `dir`  out  1  triangle direction, 0 up, 1 down, registered
- `wrap_pulse`  out  1  one-cycle flag on wrap or triangle turn, registered

## Operation
- Advance condition: `adv = ramp_enb & delta & (mode != 00)`.
- Priority per clock, highest first: `restart`, then config/range fix, then step, then hold.
- `restart` (independent of `ramp_enb`):
  - `out` = `hi` if mode = 10, else `lo`.
  - `dir` = 0; `wrap_pulse` = 0.
- Config error (`lo > hi`) on `adv`: `out` = `lo`, `dir` = 0, no pulse.
- Out-of-range on `adv` (`out < lo` or `out > hi`, e.g. after a bounds change):
  - `out` = `hi` for mode 10, else `lo`.
  - `dir` = 0; no pulse; no step applied that cycle.
- Arithmetic: sums and differences are computed in WIDTH+1 bits (sign/carry bit kept), with `step` zero-extended. No truncation before the compare.
- Saw up (01): `n = out + step`.
  - If `n <= hi`: `out = n`.
  - Otherwise, if wrapping: `out = lo` and pulse.
  - Otherwise, if saturating: `out = hi` and no pulse.
- Saw down (10): `n = out - step`.
  - If `n >= lo` (signed compare): `out = n`.
  - Otherwise, if wrapping: `out = hi` and pulse.
  - Otherwise, if saturating: `out = lo` and no pulse.
- Triangle (11), `sat_en` ignored:
  - `dir` = 0: if `out + step >= hi`, then `out = hi`, `dir = 1`, pulse; else `out += step`.
  - `dir` = 1: if `out - step <= lo`, then `out = lo`, `dir = 0`, pulse; else `out -= step`.
- `step` = 0: `out` unchanged, no pulse, `dir` unchanged.
- `lo == hi`:
  - Saw modes: `out` = `lo`; pulses on every `adv` when wrapping with `step` > 0.
  - Triangle: toggles `dir` and pulses on every `adv`.
- Mode change mid-ramp: no reload. Continues from the current `out`. Triangle resumes with the stored `dir`; `dir` is not modified in saw modes.
- `ramp_enb` = 0 or mode 00: `out` and `dir` hold, and `wrap_pulse` = 0.

## Timing
- Reset (async assert, sync release): `out` = 0, `dir` = 0, `wrap_pulse` = 0, taking effect immediately on `rst_n` falling, including mid-ramp.
- Latency: an `adv` sampled at edge k updates `out`/`dir`/`wrap_pulse` at edge k (visible after that edge). One cycle from strobe to value.
- `wrap_pulse` is high for exactly one cycle per event and deasserts on the next edge unless another event occurs.
- Back-to-back `delta` (held high) advances once per clock.
- `restart` and `delta` in the same cycle: `restart` wins, no step.
- Inputs `mode`, `step`, `lo`, `hi`, `sat_en` are sampled at the same edge as `adv`. There are no internal pipeline stages.

## Test plan
- Reset: run a saw up to `out` = 9, then pulse `rst_n` low between edges. `out`/`dir`/`wrap_pulse` must read 0 immediately; after release, with no `restart`, the first `adv` sees `out` = 0.
- Saw-up wrap vs saturate: `lo`=0, `hi`=10, `step`=3, `restart` then `delta` held.
  - `sat_en`=0: `out` 3,6,9,0 with pulse on 0.
  - `sat_en`=1: 3,6,9,10,10 with no pulse.
- Saw-down wrap: `lo`=0, `hi`=5, `step`=2, mode 10, `restart` gives 5. Then 3,1,5, with pulse on 5.
- Triangle: `lo`=2, `hi`=8, `step`=4, `restart` gives 2.
  - Sequence: 6, 8 (pulse, `dir`=1), 4, 2 (pulse, `dir`=0), 6.
- Enable/hold:
  - `ramp_enb`=0 with 3 `delta` pulses: `out` frozen.
  - `restart` while `ramp_enb`=0 still reloads `lo`.
  - Mode 00 with `delta`: frozen, `wrap_pulse`=0.
- Edge cases:
  - `out`=9, then `hi` lowered to 6 and `adv`: `out`=`lo`, no pulse.
  - `lo`=7, `hi`=3 with `adv`: `out`=7.
  - `step`=0 with `adv`: `out` unchanged.
  - WIDTH=12, `hi`=4095, `step`=255, `out`=4000: wraps to `lo`, showing no 12-bit overflow aliasing.
